// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Memory-wait sequencer states.
    typedef enum logic {
        RUN,
        WAIT
    } state_t;

    // Execute-stage operand select encodings.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one execute-stage source operand.
// The memory-stage result is newer than writeback, so it takes priority.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       we_m,
    input  logic [4:0] rd_w,
    input  logic       we_w,
    output logic [1:0] sel
);

    // x0 is never forwarded; it always reads as zero from the register file.
    always_comb begin
        sel = FWD_RF;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 core: load-use stall, branch flush,
// operand forwarding and a pipeline freeze with watchdog while a data-memory
// access is outstanding.
// Optional build macro HAZARD_PERF_EN adds three 32-bit event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RDE,
    input  logic       MemReadE,
    input  logic       PCSrcE,
    input  logic [4:0] RDM,
    input  logic       RegWriteM,
    input  logic [4:0] RDW,
    input  logic       RegWriteW,
    input  logic       mem_req_M,
    input  logic       mem_ready_M,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic       StallE,
    output logic       StallM,
    output logic       StallW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_lu_stalls,
    output logic [31:0] perf_flushes,
    output logic [31:0] perf_mem_wait
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(WAIT_TIMEOUT);

    logic             freeze;
    logic             lu;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign freeze = mem_req_M & ~mem_ready_M;
    assign lu     = MemReadE & (RDE != 5'd0) & ((RDE == Rs1D) | (RDE == Rs2D));

    fwd_sel u_fwd_a (
        .rs   (Rs1E),
        .rd_m (RDM),
        .we_m (RegWriteM),
        .rd_w (RDW),
        .we_w (RegWriteW),
        .sel  (fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs   (Rs2E),
        .rd_m (RDM),
        .we_m (RegWriteM),
        .rd_w (RDW),
        .we_w (RegWriteW),
        .sel  (fwd_b)
    );

    // Stall/flush priority: memory freeze, then taken branch, then load-use.
    // Everything is forced quiet while reset is held.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        StallW = 1'b0;
        if (!rst) begin
            // outputs stay at their defaults
        end else if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            StallW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lu) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign ForwardAE   = rst ? fwd_a : FWD_RF;
    assign ForwardBE   = rst ? fwd_b : FWD_RF;
    assign mem_timeout = timeout_q;

    // Wait sequencer: counts consecutive frozen cycles and latches the watchdog.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (freeze) begin
                    if (cnt_q < TIMEOUT_CNT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        if (freeze && (cnt_d == TIMEOUT_CNT)) begin
            timeout_d = 1'b1;
        end
    end

    // State, wait counter and sticky watchdog flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic lu_win;
    logic flush_win;

    assign flush_win = PCSrcE & ~freeze;
    assign lu_win    = lu & ~PCSrcE & ~freeze;

    // Free-running event counters; they wrap and only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lu_stalls <= '0;
            perf_flushes   <= '0;
            perf_mem_wait  <= '0;
        end else begin
            if (lu_win)    perf_lu_stalls <= perf_lu_stalls + 32'd1;
            if (flush_win) perf_flushes   <= perf_flushes + 32'd1;
            if (freeze)    perf_mem_wait  <= perf_mem_wait + 32'd1;
        end
    end
`else
    // Performance counters are not built.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, compared against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int WT = 4;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RDE, RDM, RDW;
    logic       MemReadE, PCSrcE, RegWriteM, RegWriteW, mem_req_M, mem_ready_M;
    logic       StallF, StallD, FlushD, FlushE, StallE, StallM, StallW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_stalls, perf_flushes, perf_mem_wait;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          frozen_run = 0;
    bit          exp_to = 0;
    int unsigned m_lu = 0, m_fl = 0, m_mw = 0;

    hazard_ctrl #(
        .WAIT_TIMEOUT (WT),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RDE         (RDE),
        .MemReadE    (MemReadE),
        .PCSrcE      (PCSrcE),
        .RDM         (RDM),
        .RegWriteM   (RegWriteM),
        .RDW         (RDW),
        .RegWriteW   (RegWriteW),
        .mem_req_M   (mem_req_M),
        .mem_ready_M (mem_ready_M),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .StallE      (StallE),
        .StallM      (StallM),
        .StallW      (StallW),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .mem_timeout (mem_timeout)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu_stalls (perf_lu_stalls),
        .perf_flushes   (perf_flushes),
        .perf_mem_wait  (perf_mem_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RDM != 0 && RDM == rs) return 2'b10;
        if (RegWriteW && RDW != 0 && RDW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_freeze();
        return mem_req_M && !mem_ready_M;
    endfunction

    function automatic bit m_lu_hz();
        return MemReadE && RDE != 0 && (RDE == Rs1D || RDE == Rs2D);
    endfunction

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RDE, RDM, RDW} = '0;
        {MemReadE, PCSrcE, RegWriteM, RegWriteW, mem_req_M, mem_ready_M} = '0;
    endtask

    // Called just after a rising edge with inputs already applied: checks the
    // combinational outputs mid-cycle, then advances the model over the edge.
    task automatic step();
        int win; // 0 none, 1 load-use, 2 branch, 3 memory freeze
        @(negedge clk);
        if (m_freeze()) win = 3;
        else if (PCSrcE) win = 2;
        else if (m_lu_hz()) win = 1;
        else win = 0;
        check("StallF", 32'(StallF), 32'(win == 3 || win == 1));
        check("StallD", 32'(StallD), 32'(win == 3 || win == 1));
        check("FlushD", 32'(FlushD), 32'(win == 2));
        check("FlushE", 32'(FlushE), 32'(win == 2 || win == 1));
        check("StallE", 32'(StallE), 32'(win == 3));
        check("StallM", 32'(StallM), 32'(win == 3));
        check("StallW", 32'(StallW), 32'(win == 3));
        check("ForwardAE", 32'(ForwardAE), 32'(ref_fwd(Rs1E)));
        check("ForwardBE", 32'(ForwardBE), 32'(ref_fwd(Rs2E)));
        check("mem_timeout", 32'(mem_timeout), 32'(exp_to));
        @(posedge clk);
        if (win == 3) begin
            frozen_run++;
            m_mw++;
            if (frozen_run >= WT) exp_to = 1'b1;
        end else begin
            frozen_run = 0;
        end
        if (win == 2) m_fl++;
        if (win == 1) m_lu++;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        // Hazards present during reset must not reach the outputs.
        MemReadE = 1'b1; RDE = 5'd5; Rs2D = 5'd5;
        RegWriteM = 1'b1; RDM = 5'd3; Rs1E = 5'd3; Rs2E = 5'd3;
        #3;
        check("rst_StallF", 32'(StallF), 32'd0);
        check("rst_FlushE", 32'(FlushE), 32'd0);
        check("rst_ForwardAE", 32'(ForwardAE), 32'd0);
        check("rst_ForwardBE", 32'(ForwardBE), 32'd0);
        check("rst_timeout", 32'(mem_timeout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        clear_inputs();

        // Load-use on rs2, then the hazard clears.
        MemReadE = 1'b1; RDE = 5'd5; Rs2D = 5'd5;
        step();
        clear_inputs();
        step();
        // Load into x0 is not a hazard.
        MemReadE = 1'b1; RDE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
        step();
        // Branch together with load-use: flush wins.
        MemReadE = 1'b1; RDE = 5'd9; Rs1D = 5'd9; PCSrcE = 1'b1;
        step();
        clear_inputs();

        // Forwarding: M over W, x0 skipped, no write-enable no forward.
        RegWriteM = 1'b1; RegWriteW = 1'b1; RDM = 5'd7; RDW = 5'd7; Rs1E = 5'd7;
        step();
        check("fwd_m_const", 32'(ForwardAE), 32'd2);
        RDM = 5'd0;
        step();
        RegWriteW = 1'b0;
        step();
        clear_inputs();

        // Memory wait: three frozen cycles (branch ignored), then ready.
        mem_req_M = 1'b1;
        step();
        PCSrcE = 1'b1;
        step();
        PCSrcE = 1'b0;
        step();
        mem_ready_M = 1'b1;
        step();
        check("release_StallF", 32'(StallF), 32'd0);
        clear_inputs();
        step();

        // Watchdog: six frozen cycles, sticky after release.
        mem_req_M = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 3) check("to_after4", 32'(mem_timeout), 32'd1);
        end
        mem_ready_M = 1'b1;
        step();
        clear_inputs();
        step();
        check("to_sticky", 32'(mem_timeout), 32'd1);

        // Asynchronous reset in the middle of a wait.
        mem_req_M = 1'b1;
        RegWriteM = 1'b1; RDM = 5'd4; Rs1E = 5'd4;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        check("arst_timeout", 32'(mem_timeout), 32'd0);
        check("arst_StallF", 32'(StallF), 32'd0);
        check("arst_StallW", 32'(StallW), 32'd0);
        check("arst_ForwardAE", 32'(ForwardAE), 32'd0);
        frozen_run = 0;
        exp_to = 1'b0;
        m_lu = 0; m_fl = 0; m_mw = 0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic over a small register space to provoke matches.
        for (int n = 0; n < 400; n++) begin
            Rs1D = 5'($urandom_range(0, 3));
            Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3));
            Rs2E = 5'($urandom_range(0, 3));
            RDE  = 5'($urandom_range(0, 3));
            RDM  = 5'($urandom_range(0, 3));
            RDW  = 5'($urandom_range(0, 3));
            MemReadE  = 1'($urandom_range(0, 1));
            PCSrcE    = ($urandom_range(0, 3) == 0);
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            if (n >= 200 && n < 210) begin
                mem_req_M = 1'b1; mem_ready_M = 1'b0;
            end else begin
                mem_req_M   = ($urandom_range(0, 2) == 0);
                mem_ready_M = 1'($urandom_range(0, 1));
            end
            step();
        end
        clear_inputs();
        step();

`ifdef HAZARD_PERF_EN
        check("perf_lu_stalls", perf_lu_stalls, m_lu);
        check("perf_flushes", perf_flushes, m_fl);
        check("perf_mem_wait", perf_mem_wait, m_mw);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
